// File: rtl/ppu_vec_quant.sv
// Post-processing unit: scales and biases one vector of MAC partial sums, reduces it to
// its largest magnitude, and emits symmetric-saturated OUT_W-bit lanes plus a per-vector shift.
module ppu_vec_quant #(
    parameter int LANES    = 16,
    parameter int PSUM_W   = 24,
    parameter int OUT_W    = 8,
    parameter int SCALED_W = PSUM_W + 9,
    parameter int SH_W     = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*PSUM_W-1:0]   psum,
    input  logic [7:0]                scale,
    input  logic [7:0]                bias,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic [SH_W-1:0]           out_shift,
    output logic [SCALED_W-1:0]       vec_max
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only while idle, and out_valid holds with stable data until out_ready.
    localparam int CNT_W = $clog2(LANES);
    localparam logic [SCALED_W-1:0] QMAX_U = SCALED_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SCALED_W:0] QMAX = (SCALED_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SCALED_W:0] QMIN = -QMAX;

    typedef enum logic [2:0] {S_IDLE, S_SCALE, S_REDUCE, S_QUANT, S_OUT} state_t;

    state_t                      state;
    logic [LANES*PSUM_W-1:0]     psum_r;
    logic [7:0]                  scale_r;
    logic [7:0]                  bias_r;
    logic [1:0]                  mode_r;
    logic [CNT_W-1:0]            lane_cnt;
    logic [SCALED_W-1:0]         max_abs;
    logic signed [SCALED_W-1:0]  scaled_r [LANES];

    logic signed [SCALED_W-1:0]  scaled_c [LANES];
    logic signed [SCALED_W-1:0]  cur_c;
    logic [SCALED_W-1:0]         abs_c;
    logic [SH_W-1:0]             s_c;
    logic signed [SCALED_W:0]    rnd_c;
    logic signed [SCALED_W:0]    wide_c [LANES];
    logic signed [SCALED_W:0]    shd_c [LANES];
    logic [LANES*OUT_W-1:0]      q_c;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            scaled_c[i] = $signed({{(SCALED_W-PSUM_W){psum_r[i*PSUM_W+PSUM_W-1]}}, psum_r[i*PSUM_W +: PSUM_W]})
                        * $signed({{(SCALED_W-8){1'b0}}, scale_r})
                        + $signed({{(SCALED_W-8){bias_r[7]}}, bias_r});
            if (mode_r == 2'd2 && scaled_c[i][SCALED_W-1])
                scaled_c[i] = '0;
        end
    end

    always_comb begin
        cur_c = scaled_r[lane_cnt];
        abs_c = cur_c[SCALED_W-1] ? SCALED_W'(-cur_c) : SCALED_W'(cur_c);
    end

    // Smallest shift that brings the max magnitude into the symmetric output range.
    always_comb begin
        s_c = '0;
        if (mode_r != 2'd0) begin
            for (int k = SCALED_W; k >= 0; k--) begin
                if ((max_abs >> k) <= QMAX_U)
                    s_c = SH_W'(k);
            end
        end
    end

    always_comb begin
        rnd_c = (s_c == '0) ? '0 : ((SCALED_W + 1)'(1) << (s_c - 1'b1));
        q_c   = '0;
        for (int i = 0; i < LANES; i++) begin
            wide_c[i] = $signed({scaled_r[i][SCALED_W-1], scaled_r[i]}) + rnd_c;
            shd_c[i]  = wide_c[i] >>> s_c;
            if (shd_c[i] > QMAX)
                q_c[i*OUT_W +: OUT_W] = QMAX[OUT_W-1:0];
            else if (shd_c[i] < QMIN)
                q_c[i*OUT_W +: OUT_W] = QMIN[OUT_W-1:0];
            else
                q_c[i*OUT_W +: OUT_W] = shd_c[i][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
            vec_max   <= '0;
            lane_cnt  <= '0;
            max_abs   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        psum_r   <= psum;
                        scale_r  <= scale;
                        bias_r   <= bias;
                        mode_r   <= mode;
                        in_ready <= 1'b0;
                        state    <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    scaled_r <= scaled_c;
                    max_abs  <= '0;
                    lane_cnt <= '0;
                    state    <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (abs_c > max_abs)
                        max_abs <= abs_c;
                    if (lane_cnt == CNT_W'(LANES - 1)) begin
                        lane_cnt <= '0;
                        state    <= S_QUANT;
                    end else begin
                        lane_cnt <= lane_cnt + 1'b1;
                    end
                end
                S_QUANT: begin
                    out_data  <= q_c;
                    out_shift <= s_c;
                    vec_max   <= max_abs;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ppu_vec_quant.sv
// Bench for ppu_vec_quant: directed and random vectors checked against an integer model
// of the scale / bias / ReLU / max / shift / round / saturate rules.
module tb_ppu_vec_quant;
    localparam int LANES    = 16;
    localparam int PSUM_W   = 24;
    localparam int OUT_W    = 8;
    localparam int SCALED_W = PSUM_W + 9;
    localparam int SH_W     = 6;
    localparam int RW       = SCALED_W + SH_W + LANES*OUT_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*PSUM_W-1:0] psum;
    logic [7:0]              scale;
    logic [7:0]              bias;
    logic [1:0]              mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*OUT_W-1:0]  out_data;
    logic [SH_W-1:0]         out_shift;
    logic [SCALED_W-1:0]     vec_max;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    ppu_vec_quant #(.LANES(LANES), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .psum(psum), .scale(scale), .bias(bias), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .vec_max(vec_max)
    );

    always #5 clk = ~clk;

    // Capture each output transfer just before the edge that completes it.
    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            got_q.push_back({vec_max, out_shift, out_data});

    function automatic logic [RW-1:0] model(input logic [LANES*PSUM_W-1:0] p, input logic [7:0] sc,
                                            input logic [7:0] b, input logic [1:0] m);
        longint val [LANES];
        longint mx;
        longint q;
        int s;
        logic [LANES*OUT_W-1:0] d;
        mx = 0;
        s  = 0;
        d  = '0;
        for (int i = 0; i < LANES; i++) begin
            val[i] = longint'($signed(p[i*PSUM_W +: PSUM_W])) * longint'(sc) + longint'($signed(b));
            if (m == 2'd2 && val[i] < 0) val[i] = 0;
            if (val[i] > mx) mx = val[i];
            if (-val[i] > mx) mx = -val[i];
        end
        if (m != 2'd0)
            while ((mx >> s) > 127) s++;
        for (int i = 0; i < LANES; i++) begin
            q = (val[i] + ((s > 0) ? (longint'(1) << (s - 1)) : longint'(0))) >>> s;
            if (q > 127) q = 127;
            if (q < -127) q = -127;
            d[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return {SCALED_W'(mx), SH_W'(s), d};
    endfunction

    task automatic drive_vec(input logic [LANES*PSUM_W-1:0] p, input logic [7:0] sc, input logic [7:0] b,
                             input logic [1:0] m, output int waited);
        in_valid = 1'b1;
        psum     = p;
        scale    = sc;
        bias     = b;
        mode     = m;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        waited++;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [RW-1:0] r, output bit timed_out);
        int n = 0;
        while (got_q.size() == 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        timed_out = (got_q.size() == 0);
        r = timed_out ? '0 : got_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        psum = '0;
        scale = 8'd0;
        bias = 8'd0;
        mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, vec_max, out_shift, out_data} !== {1'b1, 1'b0, {(RW){1'b0}}})
            $display("FAIL reset_state got rdy=%b vld=%b max=%h sh=%h data=%h", in_ready, out_valid, vec_max, out_shift, out_data);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [RW-1:0] r;
        logic [RW-1:0] e;
        logic [LANES*PSUM_W-1:0] p;
        logic [LANES*OUT_W-1:0] d;
        bit to;
        int w;
        int n;
        for (int i = 0; i < LANES; i++) begin
            p[i*PSUM_W +: PSUM_W] = PSUM_W'(15008);
            d[i*OUT_W +: OUT_W] = 8'd117;
        end
        e = {SCALED_W'(15008), SH_W'(7), d};
        out_ready = 1'b1;
        drive_vec(p, 8'd1, 8'd0, 2'd1, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n !== LANES + 2) $display("FAIL latency got=%0d exp=%0d", n, LANES + 2);
        else n_pass++;
        wait_result(r, to);
        n_checks++;
        if (to || r !== e) $display("FAIL latency_result got=%h exp=%h timeout=%0d", r, e, to);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [LANES*PSUM_W-1:0] p;
        logic [7:0] sc;
        logic [7:0] b;
        logic [1:0] m;
        logic [RW-1:0] r;
        logic [RW-1:0] e;
        bit to;
        int w;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < LANES; i++) begin
                case (c)
                    0:       p[i*PSUM_W +: PSUM_W] = PSUM_W'(15008);
                    1:       p[i*PSUM_W +: PSUM_W] = (i < 8) ? PSUM_W'(129794) : PSUM_W'(15008);
                    2, 3, 5: p[i*PSUM_W +: PSUM_W] = (i == 0) ? PSUM_W'(-1000) : PSUM_W'(500);
                    4:       p[i*PSUM_W +: PSUM_W] = (i % 2 == 0) ? PSUM_W'(200) : PSUM_W'(-200);
                    6:       p[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
                    7:       p[i*PSUM_W +: PSUM_W] = '0;
                    8:       p[i*PSUM_W +: PSUM_W] = {1'b1, {(PSUM_W-1){1'b0}}};
                    default: p[i*PSUM_W +: PSUM_W] = {1'b0, {(PSUM_W-1){1'b1}}};
                endcase
            end
            case (c)
                0, 1, 7: begin sc = 8'd1;   b = 8'd0;   m = 2'd1; end
                2:       begin sc = 8'd2;   b = 8'd0;   m = 2'd1; end
                3:       begin sc = 8'd2;   b = 8'd0;   m = 2'd2; end
                4:       begin sc = 8'd1;   b = 8'd1;   m = 2'd0; end
                5:       begin sc = 8'd2;   b = 8'd0;   m = 2'd3; end
                6:       begin sc = 8'd0;   b = 8'hFB;  m = 2'd1; end
                8:       begin sc = 8'd255; b = 8'h80;  m = 2'd1; end
                default: begin sc = 8'd255; b = 8'h7F;  m = 2'd1; end
            endcase
            exp_q.push_back(model(p, sc, b, m));
            drive_vec(p, sc, b, m, w);
            wait_result(r, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || r !== e) $display("FAIL directed_%0d got=%h exp=%h timeout=%0d", c, r, e, to);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*PSUM_W-1:0] p [2];
        logic [RW-1:0] r;
        logic [RW-1:0] e;
        bit to;
        int w;
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < LANES; i++)
                p[v][i*PSUM_W +: PSUM_W] = PSUM_W'($urandom_range(0, 4000)) - PSUM_W'(2000);
        exp_q.push_back(model(p[0], 8'd3, 8'd5, 2'd1));
        exp_q.push_back(model(p[1], 8'd7, 8'hF0, 2'd2));
        drive_vec(p[0], 8'd3, 8'd5, 2'd1, w);
        drive_vec(p[1], 8'd7, 8'hF0, 2'd2, w);
        n_checks++;
        if (w !== LANES + 4) $display("FAIL b2b_spacing got=%0d exp=%0d", w, LANES + 4);
        else n_pass++;
        for (int v = 0; v < 2; v++) begin
            wait_result(r, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || r !== e) $display("FAIL b2b_result_%0d got=%h exp=%h timeout=%0d", v, r, e, to);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*PSUM_W-1:0] pa;
        logic [LANES*PSUM_W-1:0] pb;
        logic [RW-1:0] ea;
        logic [RW-1:0] r;
        logic [RW-1:0] e;
        bit to;
        int w;
        int n;
        for (int i = 0; i < LANES; i++) begin
            pa[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
            pb[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom_range(0, 300));
        end
        ea = model(pa, 8'd9, 8'h11, 2'd1);
        exp_q.push_back(ea);
        exp_q.push_back(model(pb, 8'd4, 8'h83, 2'd1));
        out_ready = 1'b0;
        drive_vec(pa, 8'd9, 8'h11, 2'd1, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        psum = pb;
        scale = 8'd4;
        bias = 8'h83;
        mode = 2'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, vec_max, out_shift, out_data} !== {1'b1, 1'b0, ea})
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b out=%h exp=%h", k, out_valid, in_ready,
                         {vec_max, out_shift, out_data}, ea);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
        drive_vec(pb, 8'd4, 8'h83, 2'd1, w);
        n_checks++;
        if (w !== 1) $display("FAIL bp_second_accept got=%0d exp=1", w);
        else n_pass++;
        for (int v = 0; v < 2; v++) begin
            wait_result(r, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || r !== e) $display("FAIL bp_result_%0d got=%h exp=%h timeout=%0d", v, r, e, to);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [LANES*PSUM_W-1:0] p;
        logic [RW-1:0] r;
        bit to;
        bit seen;
        int w;
        for (int i = 0; i < LANES; i++) p[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
        out_ready = 1'b1;
        drive_vec(p, 8'd5, 8'd3, 2'd1, w);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, vec_max, out_shift, out_data} !== {1'b1, 1'b0, {(RW){1'b0}}})
            $display("FAIL rst_mid_state got rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=0", in_ready, out_valid,
                     {vec_max, out_shift, out_data});
        else n_pass++;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen || got_q.size() != 0) $display("FAIL rst_mid_no_emit got valid_seen=%0d captured=%0d exp 0 0", seen, got_q.size());
        else n_pass++;
        drive_vec('0, 8'd77, 8'd0, 2'd1, w);
        wait_result(r, to);
        n_checks++;
        if (to || r !== '0) $display("FAIL rst_mid_zero_vec got=%h exp=0 timeout=%0d", r, to);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [LANES*PSUM_W-1:0] p;
        logic [PSUM_W-1:0] l;
        logic [7:0] sc;
        logic [7:0] b;
        logic [1:0] m;
        logic [RW-1:0] r;
        logic [RW-1:0] e;
        bit to;
        int w;
        int n;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < LANES; i++) begin
                l = PSUM_W'($urandom);
                p[i*PSUM_W +: PSUM_W] = $signed(l) >>> $urandom_range(0, 20);
            end
            sc = 8'($urandom);
            b  = 8'($urandom);
            m  = 2'($urandom_range(0, 3));
            exp_q.push_back(model(p, sc, b, m));
            out_ready = 1'b0;
            drive_vec(p, sc, b, m, w);
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            wait_result(r, to);
            e = exp_q.pop_front();
            n_checks++;
            if (to || r !== e) $display("FAIL random_%0d got=%h exp=%h timeout=%0d", t, r, e, to);
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
